// File: rtl/exception_ctrl_pkg.sv
// Shared exception codes, bus widths and controller state encoding.
package exception_ctrl_pkg;
   localparam int DATA_BUS = 32;
   localparam int ADDR_BUS = 16;

   localparam logic [2:0] EXCEPT_NONE      = 3'd0;
   localparam logic [2:0] EXCEPT_INTERRUPT = 3'd1;
   localparam logic [2:0] EXCEPT_SYSCALL   = 3'd2;
   localparam logic [2:0] EXCEPT_ILLEGAL   = 3'd3;
   localparam logic [2:0] EXCEPT_TRAP      = 3'd4;
   localparam logic [2:0] EXCEPT_OVERFLOW  = 3'd5;
   localparam logic [2:0] EXCEPT_ERET      = 3'd6;

   typedef enum logic [1:0] {
      EXC_IDLE  = 2'd0,
      EXC_EXC   = 2'd1,
      EXC_REDIR = 2'd2
   } exc_state_t;
endpackage

// File: rtl/exception_ctrl_int_sync.sv
// Two-flop synchronizer for asynchronous interrupt lines.
module int_sync #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out
);
   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta     <= '0;
         sync_out <= '0;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end
endmodule

// File: rtl/exception_ctrl.sv
// CP0 exception initiator: prioritises MEM-stage faults and interrupts,
// pulses the code to CP0, flushes the pipe and redirects fetch.
module exception_ctrl
   import exception_ctrl_pkg::*;
#(
   parameter int                  DATA_WIDTH  = DATA_BUS,
   parameter int                  ADDR_WIDTH  = ADDR_BUS,
   parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR  = 16'h0040,
   parameter logic [ADDR_WIDTH-1:0] BOOT_VECTOR = 16'h0200
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_valid,
   input  logic                  pipe_mem_stall,
   input  logic [ADDR_WIDTH-1:0] mem_pc,
   input  logic                  mem_in_delay_slot,
   input  logic                  mem_syscall,
   input  logic                  mem_illegal,
   input  logic                  mem_trap,
   input  logic                  mem_overflow,
   input  logic                  mem_eret,
   input  logic [5:0]            hw_int,
   input  logic [31:0]           cp0_status,
   input  logic [31:0]           cp0_cause,
   input  logic [ADDR_WIDTH-1:0] cp0_epc,
   output logic [DATA_WIDTH-1:0] exception,
   output logic [ADDR_WIDTH-1:0] exception_pc,
   output logic                  exception_bd,
   output logic                  flush,
   output logic                  redirect_valid,
   output logic [ADDR_WIDTH-1:0] redirect_pc,
   input  logic                  redirect_ready
);
   exc_state_t state;
   logic [5:0] sync_hw;
   logic [7:0] ip;
   logic       int_req;
   logic [2:0] code;
   logic       accept;
   logic       is_eret;
   logic       unused_bits;

   int_sync #(.WIDTH(6)) u_int_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (hw_int),
      .sync_out (sync_hw)
   );

   assign ip          = {sync_hw, cp0_cause[9:8]};
   // Masked request only when IE=1 and not already at exception level.
   assign int_req     = (|(ip & cp0_status[15:8])) & cp0_status[0] & ~cp0_status[1];
   assign unused_bits = ^{cp0_status[31:23], cp0_status[21:16], cp0_status[7:2],
                          cp0_cause[31:10], cp0_cause[7:0]};

   always_comb begin
      code = EXCEPT_NONE;
      if      (int_req)      code = EXCEPT_INTERRUPT;
      else if (mem_illegal)  code = EXCEPT_ILLEGAL;
      else if (mem_overflow) code = EXCEPT_OVERFLOW;
      else if (mem_trap)     code = EXCEPT_TRAP;
      else if (mem_syscall)  code = EXCEPT_SYSCALL;
      else if (mem_eret)     code = EXCEPT_ERET;
   end

   assign is_eret = (code == EXCEPT_ERET);
   assign accept  = (state == EXC_IDLE) & mem_valid & ~pipe_mem_stall & (code != EXCEPT_NONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= EXC_IDLE;
         exception      <= '0;
         exception_pc   <= '0;
         exception_bd   <= 1'b0;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         case (state)
            EXC_IDLE: if (accept) begin
               state        <= EXC_EXC;
               exception    <= DATA_WIDTH'(code);
               flush        <= 1'b1;
               exception_bd <= ~is_eret & mem_in_delay_slot;
               if (is_eret)                exception_pc <= '0;
               else if (mem_in_delay_slot) exception_pc <= mem_pc - ADDR_WIDTH'(4);
               else                        exception_pc <= mem_pc;
               if (is_eret)                redirect_pc  <= cp0_epc;
               else if (cp0_status[22])    redirect_pc  <= BOOT_VECTOR;
               else                        redirect_pc  <= EXC_VECTOR;
            end
            EXC_EXC: begin
               state          <= EXC_REDIR;
               exception      <= DATA_WIDTH'(EXCEPT_NONE);
               redirect_valid <= 1'b1;
            end
            EXC_REDIR: if (redirect_ready) begin
               state          <= EXC_IDLE;
               flush          <= 1'b0;
               redirect_valid <= 1'b0;
            end
            default: state <= EXC_IDLE;
         endcase
      end
   end
endmodule
